// File: rtl/prog_sequencer.sv
// Program sequencer: launches each program of a packed series on Start release,
// gates instruction fetch, and reports completion, watchdog expiry and RUN cycle count.
module prog_sequencer #(
    parameter int                         NUM_PROGS = 3,
    parameter int                         PC_W      = 10,
    parameter logic [NUM_PROGS*PC_W-1:0]  PROG_BASE = '0,
    parameter int                         CNT_W     = 16,
    parameter logic [CNT_W-1:0]           TIMEOUT   = {CNT_W{1'b1}},
    localparam int                        IDX_W     = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Halt,
    output logic             PcLoad,
    output logic [PC_W-1:0]  PcLoadAddr,
    output logic             FetchHold,
    output logic             Busy,
    output logic             Done,
    output logic             AllDone,
    output logic             TimedOut,
    output logic [IDX_W-1:0] ProgIdx,
    output logic [CNT_W-1:0] CycleCnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        RUN    = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_PROGS - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_M1 = TIMEOUT - CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    function automatic logic [PC_W-1:0] base_addr(input logic [IDX_W-1:0] idx);
        logic [PC_W-1:0] addr;
        addr = PROG_BASE[PC_W-1:0];
        for (int i = 0; i < NUM_PROGS; i++) begin
            if (idx == IDX_W'(i)) begin
                addr = PROG_BASE[i*PC_W +: PC_W];
            end else begin
                addr = addr;
            end
        end
        return addr;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? {IDX_W{1'b0}} : idx + IDX_W'(1);
    endfunction

    state_t           state_q, state_d;
    logic [IDX_W-1:0] prog_idx_q, prog_idx_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic             timed_out_q, timed_out_d;
    logic             pc_load_q, pc_load_d;
    logic [PC_W-1:0]  pc_addr_q, pc_addr_d;
    logic             fetch_hold_q, fetch_hold_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             all_done_q, all_done_d;

    // Next-state and next-output computation; outputs are decoded from the next state
    // so every port comes straight from a flop.
    always_comb begin
        state_d     = state_q;
        prog_idx_d  = prog_idx_q;
        cycle_cnt_d = cycle_cnt_q;
        timed_out_d = timed_out_q;
        case (state_q)
            IDLE: begin
                if (Start) state_d = ARMED;
                else       state_d = IDLE;
            end
            ARMED: begin
                if (!Start) state_d = RUN;
                else        state_d = ARMED;
            end
            RUN: begin
                cycle_cnt_d = (cycle_cnt_q == CNT_MAX) ? CNT_MAX : cycle_cnt_q + CNT_W'(1);
                // Restart wins over both halt and watchdog in the same cycle.
                if (Start) begin
                    state_d = ARMED;
                end else if (Halt) begin
                    state_d = HALTED;
                end else if (cycle_cnt_q == TIMEOUT_M1) begin
                    state_d     = HALTED;
                    timed_out_d = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            HALTED: begin
                if (Start) begin
                    state_d    = ARMED;
                    prog_idx_d = next_idx(prog_idx_q);
                end else begin
                    state_d = HALTED;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == ARMED) begin
            cycle_cnt_d = {CNT_W{1'b0}};
            timed_out_d = 1'b0;
        end else begin
            cycle_cnt_d = cycle_cnt_d;
            timed_out_d = timed_out_d;
        end

        pc_load_d    = (state_d == ARMED);
        pc_addr_d    = base_addr(prog_idx_d);
        fetch_hold_d = (state_d != RUN);
        busy_d       = (state_d == RUN);
        done_d       = (state_d == HALTED);
        all_done_d   = (state_d == HALTED) && (prog_idx_d == LAST_IDX);
    end

    // State and registered-output flops.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            prog_idx_q   <= {IDX_W{1'b0}};
            cycle_cnt_q  <= {CNT_W{1'b0}};
            timed_out_q  <= 1'b0;
            pc_load_q    <= 1'b0;
            pc_addr_q    <= PROG_BASE[PC_W-1:0];
            fetch_hold_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            all_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            prog_idx_q   <= prog_idx_d;
            cycle_cnt_q  <= cycle_cnt_d;
            timed_out_q  <= timed_out_d;
            pc_load_q    <= pc_load_d;
            pc_addr_q    <= pc_addr_d;
            fetch_hold_q <= fetch_hold_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            all_done_q   <= all_done_d;
        end
    end

    assign PcLoad     = pc_load_q;
    assign PcLoadAddr = pc_addr_q;
    assign FetchHold  = fetch_hold_q;
    assign Busy       = busy_q;
    assign Done       = done_q;
    assign AllDone    = all_done_q;
    assign TimedOut   = timed_out_q;
    assign ProgIdx    = prog_idx_q;
    assign CycleCnt   = cycle_cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed testbench for prog_sequencer: three programs at 0/96/200, watchdog of 8 cycles.
module tb_prog_sequencer;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic        Halt;
    logic        PcLoad;
    logic [9:0]  PcLoadAddr;
    logic        FetchHold;
    logic        Busy;
    logic        Done;
    logic        AllDone;
    logic        TimedOut;
    logic [1:0]  ProgIdx;
    logic [15:0] CycleCnt;

    int vectors;
    int miscompares;

    prog_sequencer #(
        .NUM_PROGS (3),
        .PC_W      (10),
        .PROG_BASE ({10'd200, 10'd96, 10'd0}),
        .CNT_W     (16),
        .TIMEOUT   (16'd8)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Halt       (Halt),
        .PcLoad     (PcLoad),
        .PcLoadAddr (PcLoadAddr),
        .FetchHold  (FetchHold),
        .Busy       (Busy),
        .Done       (Done),
        .AllDone    (AllDone),
        .TimedOut   (TimedOut),
        .ProgIdx    (ProgIdx),
        .CycleCnt   (CycleCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int pl, input int addr, input int fh,
                              input int busy, input int done, input int alld, input int to,
                              input int idx, input int cnt);
        chk({tag, ".PcLoad"},     32'(PcLoad),     32'(pl));
        chk({tag, ".PcLoadAddr"}, 32'(PcLoadAddr), 32'(addr));
        chk({tag, ".FetchHold"},  32'(FetchHold),  32'(fh));
        chk({tag, ".Busy"},       32'(Busy),       32'(busy));
        chk({tag, ".Done"},       32'(Done),       32'(done));
        chk({tag, ".AllDone"},    32'(AllDone),    32'(alld));
        chk({tag, ".TimedOut"},   32'(TimedOut),   32'(to));
        chk({tag, ".ProgIdx"},    32'(ProgIdx),    32'(idx));
        chk({tag, ".CycleCnt"},   32'(CycleCnt),   32'(cnt));
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        Reset = 1'b1;
        Start = 1'b0;
        Halt  = 1'b0;
        tick(2);
        Reset = 1'b0;
        tick(1);
        expect_out("reset", 0, 0, 1, 0, 0, 0, 0, 0, 0);

        // Start held three cycles: PcLoad at base 0 each cycle
        Start = 1'b1;
        tick(1); expect_out("arm_a", 1, 0, 1, 0, 0, 0, 0, 0, 0);
        tick(1); expect_out("arm_b", 1, 0, 1, 0, 0, 0, 0, 0, 0);
        tick(1); expect_out("arm_c", 1, 0, 1, 0, 0, 0, 0, 0, 0);
        Start = 1'b0;
        tick(1); expect_out("run0", 0, 0, 0, 1, 0, 0, 0, 0, 0);
        tick(4); expect_out("run4", 0, 0, 0, 1, 0, 0, 0, 0, 4);
        Halt = 1'b1;
        tick(1); expect_out("halt1", 0, 0, 1, 0, 1, 0, 0, 0, 5);
        // Halt while already halted is ignored
        tick(1); expect_out("halt_in_halted", 0, 0, 1, 0, 1, 0, 0, 0, 5);
        Halt = 1'b0;

        // Second program; Halt during ARMED is ignored
        Start = 1'b1;
        tick(1); expect_out("arm2", 1, 96, 1, 0, 0, 0, 0, 1, 0);
        Start = 1'b0;
        Halt  = 1'b1;
        tick(1); expect_out("run2_armed_halt", 0, 96, 0, 1, 0, 0, 0, 1, 0);
        Halt = 1'b0;
        tick(2); expect_out("run2_c2", 0, 96, 0, 1, 0, 0, 0, 1, 2);
        Halt = 1'b1;
        tick(1); expect_out("halt2", 0, 96, 1, 0, 1, 0, 0, 1, 3);
        Halt = 1'b0;

        // Third (last) program raises AllDone
        Start = 1'b1;
        tick(1); expect_out("arm3", 1, 200, 1, 0, 0, 0, 0, 2, 0);
        Start = 1'b0;
        tick(1); expect_out("run3", 0, 200, 0, 1, 0, 0, 0, 2, 0);
        Halt = 1'b1;
        tick(1); expect_out("halt3", 0, 200, 1, 0, 1, 1, 0, 2, 1);
        Halt = 1'b0;

        // Fourth Start wraps to program 0 and clears AllDone
        Start = 1'b1;
        tick(1); expect_out("arm_wrap", 1, 0, 1, 0, 0, 0, 0, 0, 0);
        Start = 1'b0;
        tick(1); expect_out("run_wrap", 0, 0, 0, 1, 0, 0, 0, 0, 0);

        // Watchdog: no Halt, 8 RUN cycles
        tick(7); expect_out("run7", 0, 0, 0, 1, 0, 0, 0, 0, 7);
        tick(1); expect_out("timeout", 0, 0, 1, 0, 1, 0, 1, 0, 8);
        Start = 1'b1;
        tick(1); expect_out("arm_after_to", 1, 96, 1, 0, 0, 0, 0, 1, 0);
        Start = 1'b0;
        tick(1);
        tick(2); expect_out("run_pre_abort", 0, 96, 0, 1, 0, 0, 0, 1, 2);

        // Start and Halt together in RUN: restart same program
        Start = 1'b1;
        Halt  = 1'b1;
        tick(1); expect_out("abort", 1, 96, 1, 0, 0, 0, 0, 1, 0);
        Start = 1'b0;
        Halt  = 1'b0;
        tick(1);
        tick(1); expect_out("run_pre_reset", 0, 96, 0, 1, 0, 0, 0, 1, 1);

        // Asynchronous reset mid-RUN, checked before the next edge
        #2 Reset = 1'b1;
        #1 expect_out("async_reset", 0, 0, 1, 0, 0, 0, 0, 0, 0);
        #2 Reset = 1'b0;

        // Halt in IDLE is ignored
        Halt = 1'b1;
        tick(1); expect_out("idle_halt", 0, 0, 1, 0, 0, 0, 0, 0, 0);
        Halt = 1'b0;
        tick(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
